mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the Dcache MSHR and the Icache controller.
- Multiplexes their proc2mem requests onto the single memory port.
- Records which requester owns each outstanding load tag, and steers mem2proc_tag/mem2proc_data back to that owner.
- Exposes an idle flag so the Dcache write-back/halt sequence can tell when the memory port is quiet.

Parameters:
- NUM_TAGS, 16: tag space of memory (tag 0 = none). The table holds tags 1..NUM_TAGS-1.
- MAX_WAIT, 8: cycles the Icache may be refused before it gains priority over the Dcache.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- d_proc2mem_command  in  2  Dcache MSHR command (BUS_NONE/BUS_LOAD/BUS_STORE)
- d_proc2mem_addr  in  64  Dcache address
- d_proc2mem_data  in  64  Dcache store data
- i_proc2mem_command  in  2  Icache command (BUS_NONE/BUS_LOAD only)
- i_proc2mem_addr  in  64  Icache address
- mem2proc_response  in  4  memory accept tag, same cycle as the command; 0 = rejected
- mem2proc_data  in  64  returning load data
- mem2proc_tag  in  4  tag of returning data; 0 = none
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  64  address to memory
- proc2mem_data  out  64  store data to memory
- d_mem2proc_response  out  4  response routed to the Dcache
- i_mem2proc_response  out  4  response routed to the Icache
- d_mem2proc_tag  out  4  returning tag routed to the Dcache
- i_mem2proc_tag  out  4  returning tag routed to the Icache
- d_mem2proc_data / i_mem2proc_data  out  64  returning data (both driven with mem2proc_data)
- mem_idle  out  1  no outstanding load tags and no request this cycle
- tag_error  out  1  sticky; set when an unknown tag returns or a duplicate tag is accepted

Behaviour:
- Reset (reset==0, async):
  - owner table cleared (all entries invalid).
  - starvation counter = 0, tag_error = 0.
  - All combinational outputs are derived from cleared state, so with idle inputs: all commands BUS_NONE, all tags/responses 0, mem_idle = 1.
- Grant, combinational in the same cycle:
  - Only one requester active: that requester is granted.
  - Both active: the Dcache is granted unless starve_cnt >= MAX_WAIT, in which case the Icache is granted.
  - The proc2mem_* outputs mirror the granted requester. When the Icache is granted, proc2mem_data = 0.
  - No requester: proc2mem_command = BUS_NONE.
- Response routing:
  - mem2proc_response goes to the granted requester's *_mem2proc_response.
  - The other requester sees 0 that cycle. Its request is not accepted and it must hold it.
- Starvation counter:
  - Increments, saturating at 2^CNT_W-1, on each cycle the Icache requests and its response is 0.
  - Clears to 0 on any cycle the Icache's response is nonzero.
- Owner table (registered):
  - When a BUS_LOAD is granted and mem2proc_response != 0, entry[response] becomes valid, with owner = D or I, on the next edge.
  - BUS_STORE never creates an entry.
  - Accepting a tag whose entry is already valid sets tag_error; the entry is overwritten.
- Data return:
  - When mem2proc_tag != 0 and entry[tag] is valid, the tag goes to the owner's *_mem2proc_tag in the same cycle. The other side sees 0. The entry is cleared on the next edge.
  - Invalid entry: both tag outputs are 0 and tag_error is set.
- Simultaneous events:
  - A return with tag T and a new accept with tag T in the same cycle: the return is routed using the old owner, and the entry ends valid with the new owner.
  - The set has priority over the clear.
- mem_idle = (no valid entries) & (proc2mem_command == BUS_NONE).
- An outstanding-entry count (0..NUM_TAGS-1) is kept as a register, updated by +1 / -1 / 0. This avoids a 15-input reduction in the idle path.
- Reset mid-operation discards all entries. Data later returning with old tags raises tag_error; this is acceptable because memory is also reset.

Decomposition:
- Shared package:
  - BUS_COMMAND enum (BUS_NONE/BUS_LOAD/BUS_STORE), already shared.
  - MEM_OWNER_t enum {OWNER_D, OWNER_I}.
  - MEM_TAG_ENTRY_t struct {valid, owner}.
  - `mem_tag_table_reset constant.
- One sub-module, mem_tag_table: owner table, outstanding count, set/clear/lookup ports.
- Grant, starvation and muxing logic stay in the top module.

Test Plan:
- Dcache-only load at 0x100, memory responds tag 3, later tag 3 returns with data 0xAB → d_mem2proc_response=3; on return d_mem2proc_tag=3, d_data=0xAB, i_tag=0; mem_idle=1 afterwards.
- Both request loads for 8 consecutive cycles (MAX_WAIT=8), memory always accepts → Dcache granted in cycles 0-7, Icache granted in cycle 8, counter back to 0 the cycle after.
- Icache load accepted as tag 5, Dcache BUS_STORE accepted as tag 6 → entry 5 = OWNER_I; no entry for 6; a return of tag 6 sets tag_error and drives both tag outputs 0.
- Return of tag 4 (owner D) in the same cycle the Icache is accepted as tag 4 → d_mem2proc_tag=4; next cycle entry 4 = OWNER_I, count unchanged.
- Memory rejects (response 0) the Dcache load → no entry created; the Dcache holds its request; the retry is accepted as tag 2 and routed correctly.
- Assert reset low asynchronously between edges with 3 entries outstanding → table, count and tag_error cleared immediately; mem_idle=1 with idle inputs.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus command encoding and load-tag owner table types.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic {
      OWNER_D = 1'b0,
      OWNER_I = 1'b1
   } MEM_OWNER_t;

   typedef struct packed {
      logic       valid;
      MEM_OWNER_t owner;
   } MEM_TAG_ENTRY_t;

   localparam MEM_TAG_ENTRY_t MEM_TAG_TABLE_RESET = '{valid: 1'b0, owner: OWNER_D};

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// Owner table for outstanding memory load tags, with a running count of
// valid entries so the idle flag does not need a wide reduction.
module mem_tag_table
   import mem_bus_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_TAGS = 16,
   localparam int unsigned TAG_W    = $clog2(NUM_TAGS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             set_en,
   input  logic [TAG_W-1:0] set_tag,
   input  MEM_OWNER_t       set_owner,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             lookup_hit,
   output MEM_OWNER_t       lookup_owner,
   output logic             set_dup,
   output logic             any_valid
);

   MEM_TAG_ENTRY_t   entries_q [NUM_TAGS];
   logic [TAG_W-1:0] count_q;
   logic             inc;
   logic             dec;

   // Lookup of the returning tag and occupancy bookkeeping.
   always_comb begin
      lookup_hit   = (lookup_tag != '0) && entries_q[lookup_tag].valid;
      lookup_owner = entries_q[lookup_tag].owner;
      set_dup      = entries_q[set_tag].valid;
      any_valid    = (count_q != '0);
      // A set on the tag being returned this cycle keeps the entry valid,
      // so the net occupancy change is zero.
      inc = set_en && !entries_q[set_tag].valid;
      dec = lookup_hit && !(set_en && (set_tag == lookup_tag));
   end

   // Table and count registers; a set overrides a clear of the same tag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            entries_q[i] <= MEM_TAG_TABLE_RESET;
         end
         count_q <= '0;
      end else begin
         if (lookup_hit) begin
            entries_q[lookup_tag] <= MEM_TAG_TABLE_RESET;
         end
         if (set_en) begin
            entries_q[set_tag] <= '{valid: 1'b1, owner: set_owner};
         end
         if (inc && !dec) begin
            count_q <= count_q + TAG_W'(1);
         end else if (dec && !inc) begin
            count_q <= count_q - TAG_W'(1);
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates Dcache and Icache requests onto one memory port and routes
// returning load tags back to whichever side issued them.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_TAGS = 16,
   parameter int unsigned MAX_WAIT = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [1:0]                  d_proc2mem_command,
   input  logic [63:0]                 d_proc2mem_addr,
   input  logic [63:0]                 d_proc2mem_data,
   input  logic [1:0]                  i_proc2mem_command,
   input  logic [63:0]                 i_proc2mem_addr,
   input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_response,
   input  logic [63:0]                 mem2proc_data,
   input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_tag,
   output logic [1:0]                  proc2mem_command,
   output logic [63:0]                 proc2mem_addr,
   output logic [63:0]                 proc2mem_data,
   output logic [$clog2(NUM_TAGS)-1:0] d_mem2proc_response,
   output logic [$clog2(NUM_TAGS)-1:0] i_mem2proc_response,
   output logic [$clog2(NUM_TAGS)-1:0] d_mem2proc_tag,
   output logic [$clog2(NUM_TAGS)-1:0] i_mem2proc_tag,
   output logic [63:0]                 d_mem2proc_data,
   output logic [63:0]                 i_mem2proc_data,
   output logic                        mem_idle,
   output logic                        tag_error
);

   localparam int unsigned TAG_W = $clog2(NUM_TAGS);

   BUS_COMMAND d_cmd;
   BUS_COMMAND i_cmd;
   logic       d_req;
   logic       i_req;
   logic       grant_d;
   logic       grant_i;
   logic [CNT_W-1:0] starve_q;

   logic       set_en;
   MEM_OWNER_t set_owner;
   logic       lookup_hit;
   MEM_OWNER_t lookup_owner;
   logic       set_dup;
   logic       any_valid;

   assign d_cmd = BUS_COMMAND'(d_proc2mem_command);
   assign i_cmd = BUS_COMMAND'(i_proc2mem_command);

   // Grant selection, request muxing and response/tag steering.
   always_comb begin
      d_req   = (d_cmd != BUS_NONE);
      i_req   = (i_cmd != BUS_NONE);
      grant_i = i_req && (!d_req || (starve_q >= CNT_W'(MAX_WAIT)));
      grant_d = d_req && !grant_i;

      proc2mem_command    = BUS_NONE;
      proc2mem_addr       = '0;
      proc2mem_data       = '0;
      d_mem2proc_response = '0;
      i_mem2proc_response = '0;
      set_en              = 1'b0;
      set_owner           = OWNER_D;

      if (grant_d) begin
         proc2mem_command    = d_cmd;
         proc2mem_addr       = d_proc2mem_addr;
         proc2mem_data       = d_proc2mem_data;
         d_mem2proc_response = mem2proc_response;
         set_en              = (d_cmd == BUS_LOAD) && (mem2proc_response != '0);
      end else if (grant_i) begin
         proc2mem_command    = i_cmd;
         proc2mem_addr       = i_proc2mem_addr;
         i_mem2proc_response = mem2proc_response;
         set_en              = (i_cmd == BUS_LOAD) && (mem2proc_response != '0);
         set_owner           = OWNER_I;
      end

      d_mem2proc_tag  = (lookup_hit && (lookup_owner == OWNER_D)) ? mem2proc_tag : '0;
      i_mem2proc_tag  = (lookup_hit && (lookup_owner == OWNER_I)) ? mem2proc_tag : '0;
      d_mem2proc_data = mem2proc_data;
      i_mem2proc_data = mem2proc_data;
      mem_idle        = !any_valid && (proc2mem_command == BUS_NONE);
   end

   // Icache starvation counter and sticky tag error flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_q  <= '0;
         tag_error <= 1'b0;
      end else begin
         if (i_mem2proc_response != '0) begin
            starve_q <= '0;
         end else if (i_req && (starve_q != '1)) begin
            starve_q <= starve_q + CNT_W'(1);
         end
         if ((set_en && set_dup) || ((mem2proc_tag != '0) && !lookup_hit)) begin
            tag_error <= 1'b1;
         end
      end
   end

   mem_tag_table #(
      .NUM_TAGS (NUM_TAGS)
   ) u_tag_table (
      .clock        (clock),
      .reset        (reset),
      .set_en       (set_en),
      .set_tag      (mem2proc_response[TAG_W-1:0]),
      .set_owner    (set_owner),
      .lookup_tag   (mem2proc_tag[TAG_W-1:0]),
      .lookup_hit   (lookup_hit),
      .lookup_owner (lookup_owner),
      .set_dup      (set_dup),
      .any_valid    (any_valid)
   );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic        clock;
   logic        reset;
   logic [1:0]  d_proc2mem_command;
   logic [63:0] d_proc2mem_addr;
   logic [63:0] d_proc2mem_data;
   logic [1:0]  i_proc2mem_command;
   logic [63:0] i_proc2mem_addr;
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0]  d_mem2proc_response;
   logic [3:0]  i_mem2proc_response;
   logic [3:0]  d_mem2proc_tag;
   logic [3:0]  i_mem2proc_tag;
   logic [63:0] d_mem2proc_data;
   logic [63:0] i_mem2proc_data;
   logic        mem_idle;
   logic        tag_error;

   mem_bus_arbiter #(
      .NUM_TAGS (16),
      .MAX_WAIT (8),
      .CNT_W    (4)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .d_proc2mem_command  (d_proc2mem_command),
      .d_proc2mem_addr     (d_proc2mem_addr),
      .d_proc2mem_data     (d_proc2mem_data),
      .i_proc2mem_command  (i_proc2mem_command),
      .i_proc2mem_addr     (i_proc2mem_addr),
      .mem2proc_response   (mem2proc_response),
      .mem2proc_data       (mem2proc_data),
      .mem2proc_tag        (mem2proc_tag),
      .proc2mem_command    (proc2mem_command),
      .proc2mem_addr       (proc2mem_addr),
      .proc2mem_data       (proc2mem_data),
      .d_mem2proc_response (d_mem2proc_response),
      .i_mem2proc_response (i_mem2proc_response),
      .d_mem2proc_tag      (d_mem2proc_tag),
      .i_mem2proc_tag      (i_mem2proc_tag),
      .d_mem2proc_data     (d_mem2proc_data),
      .i_mem2proc_data     (i_mem2proc_data),
      .mem_idle            (mem_idle),
      .tag_error           (tag_error)
   );

   typedef struct {
      string       name;
      logic [1:0]  cmd;
      logic [63:0] addr;
      logic [63:0] data;
      logic [3:0]  dr;
      logic [3:0]  ir;
      logic [3:0]  dt;
      logic [3:0]  it;
      logic [63:0] rdata;
      logic        idle;
      logic        terr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input string field, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
      end
   endtask

   // Monitor: compares the pending expectation against the DUT mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "cmd",    64'(proc2mem_command),    64'(e.cmd));
            chk(e.name, "addr",   proc2mem_addr,            e.addr);
            chk(e.name, "data",   proc2mem_data,            e.data);
            chk(e.name, "d_resp", 64'(d_mem2proc_response), 64'(e.dr));
            chk(e.name, "i_resp", 64'(i_mem2proc_response), 64'(e.ir));
            chk(e.name, "d_tag",  64'(d_mem2proc_tag),      64'(e.dt));
            chk(e.name, "i_tag",  64'(i_mem2proc_tag),      64'(e.it));
            chk(e.name, "d_data", d_mem2proc_data,          e.rdata);
            chk(e.name, "i_data", i_mem2proc_data,          e.rdata);
            chk(e.name, "idle",   64'(mem_idle),            64'(e.idle));
            chk(e.name, "terr",   64'(tag_error),           64'(e.terr));
         end
      end
   end

   task automatic push(input string nm, input logic [1:0] ecmd, input logic [63:0] eaddr, edata,
                       input logic [3:0] edr, eir, edt, eit, input logic [63:0] erdata,
                       input logic eidle, eterr);
      exp_t e;
      e.name = nm; e.cmd = ecmd; e.addr = eaddr; e.data = edata;
      e.dr = edr; e.ir = eir; e.dt = edt; e.it = eit; e.rdata = erdata;
      e.idle = eidle; e.terr = eterr;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [1:0] dc, input logic [63:0] da, dd, input logic [1:0] ic,
                        input logic [63:0] ia, input logic [3:0] resp, rtag, input logic [63:0] rdata);
      d_proc2mem_command = dc; d_proc2mem_addr = da; d_proc2mem_data = dd;
      i_proc2mem_command = ic; i_proc2mem_addr = ia;
      mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdata;
   endtask

   // One clock of stimulus plus its hand-computed expected response.
   task automatic go(input string nm,
                     input logic [1:0] dc, input logic [63:0] da, dd,
                     input logic [1:0] ic, input logic [63:0] ia,
                     input logic [3:0] resp, rtag, input logic [63:0] rdata,
                     input logic [1:0] ecmd, input logic [63:0] eaddr, edata,
                     input logic [3:0] edr, eir, edt, eit, input logic eidle, eterr);
      @(posedge clock);
      #1;
      drive(dc, da, dd, ic, ia, resp, rtag, rdata);
      push(nm, ecmd, eaddr, edata, edr, eir, edt, eit, rdata, eidle, eterr);
   endtask

   task automatic idle_cycle(input string nm, input logic eidle, eterr);
      go(nm, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0, BUS_NONE, 0, 0, 0, 0, 0, 0, eidle, eterr);
   endtask

   initial begin
      reset = 1'b0;
      drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
      #1;
      push("reset", BUS_NONE, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Dcache-only load, tag 3, later returned with 0xAB
      go("t1_acc", BUS_LOAD, 64'h100, 0, BUS_NONE, 0, 4'd3, 0, 0,
         BUS_LOAD, 64'h100, 0, 4'd3, 0, 0, 0, 1'b0, 1'b0);
      idle_cycle("t1_wait", 1'b0, 1'b0);
      go("t1_ret", BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd3, 64'hAB,
         BUS_NONE, 0, 0, 0, 0, 4'd3, 0, 1'b0, 1'b0);
      idle_cycle("t1_idle", 1'b1, 1'b0);

      // Both request; Dcache wins 8 times, then starvation hands cycle 8 to Icache
      for (int k = 0; k < 8; k++) begin
         go($sformatf("t2_d%0d", k), BUS_LOAD, 64'h200, 0, BUS_LOAD, 64'h300, 4'(k + 1), 0, 0,
            BUS_LOAD, 64'h200, 0, 4'(k + 1), 0, 0, 0, 1'b0, 1'b0);
      end
      go("t2_i8", BUS_LOAD, 64'h200, 0, BUS_LOAD, 64'h300, 4'd9, 0, 0,
         BUS_LOAD, 64'h300, 0, 0, 4'd9, 0, 0, 1'b0, 1'b0);
      go("t2_d9", BUS_LOAD, 64'h200, 0, BUS_LOAD, 64'h300, 4'd10, 0, 0,
         BUS_LOAD, 64'h200, 0, 4'd10, 0, 0, 0, 1'b0, 1'b0);
      for (int t = 1; t <= 10; t++) begin
         go($sformatf("t2_ret%0d", t), BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'(t), 64'h1000 + 64'(t),
            BUS_NONE, 0, 0, 0, 0, (t == 9) ? 4'd0 : 4'(t), (t == 9) ? 4'd9 : 4'd0, 1'b0, 1'b0);
      end
      idle_cycle("t2_idle", 1'b1, 1'b0);

      // Icache load tag 5, Dcache store tag 6 (no entry), bogus return of 6
      go("t3_iacc", BUS_NONE, 0, 0, BUS_LOAD, 64'h400, 4'd5, 0, 0,
         BUS_LOAD, 64'h400, 0, 0, 4'd5, 0, 0, 1'b0, 1'b0);
      go("t3_st", BUS_STORE, 64'h500, 64'hDEAD, BUS_NONE, 0, 4'd6, 0, 0,
         BUS_STORE, 64'h500, 64'hDEAD, 4'd6, 0, 0, 0, 1'b0, 1'b0);
      go("t3_bad", BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd6, 64'h66,
         BUS_NONE, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      idle_cycle("t3_err", 1'b0, 1'b1);

      // Tag 4 returns to Dcache while the Icache is accepted as tag 4
      go("t4_dacc", BUS_LOAD, 64'h600, 0, BUS_NONE, 0, 4'd4, 0, 0,
         BUS_LOAD, 64'h600, 0, 4'd4, 0, 0, 0, 1'b0, 1'b1);
      go("t4_swap", BUS_NONE, 0, 0, BUS_LOAD, 64'h700, 4'd4, 4'd4, 64'h44,
         BUS_LOAD, 64'h700, 0, 0, 4'd4, 4'd4, 0, 1'b0, 1'b1);
      go("t4_ret4", BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd4, 64'h45,
         BUS_NONE, 0, 0, 0, 0, 0, 4'd4, 1'b0, 1'b1);
      go("t4_ret5", BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd5, 64'h55,
         BUS_NONE, 0, 0, 0, 0, 0, 4'd5, 1'b0, 1'b1);
      idle_cycle("t4_idle", 1'b1, 1'b1);

      // Rejected Dcache load, held and retried, accepted as tag 2
      go("t5_rej", BUS_LOAD, 64'h800, 0, BUS_NONE, 0, 4'd0, 0, 0,
         BUS_LOAD, 64'h800, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      go("t5_retry", BUS_LOAD, 64'h800, 0, BUS_NONE, 0, 4'd2, 0, 0,
         BUS_LOAD, 64'h800, 0, 4'd2, 0, 0, 0, 1'b0, 1'b1);
      idle_cycle("t5_wait", 1'b0, 1'b1);
      go("t5_ret", BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd2, 64'h1234,
         BUS_NONE, 0, 0, 0, 0, 4'd2, 0, 1'b0, 1'b1);
      idle_cycle("t5_idle", 1'b1, 1'b1);

      // Three outstanding entries, then async reset between edges
      go("t6_d7", BUS_LOAD, 64'hA00, 0, BUS_NONE, 0, 4'd7, 0, 0,
         BUS_LOAD, 64'hA00, 0, 4'd7, 0, 0, 0, 1'b0, 1'b1);
      go("t6_d8", BUS_LOAD, 64'hA08, 0, BUS_NONE, 0, 4'd8, 0, 0,
         BUS_LOAD, 64'hA08, 0, 4'd8, 0, 0, 0, 1'b0, 1'b1);
      go("t6_i9", BUS_NONE, 0, 0, BUS_LOAD, 64'hB00, 4'd9, 0, 0,
         BUS_LOAD, 64'hB00, 0, 0, 4'd9, 0, 0, 1'b0, 1'b1);
      idle_cycle("t6_hold", 1'b0, 1'b1);
      @(posedge clock);
      #2;
      drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
      reset = 1'b0;
      push("t6_rst", BUS_NONE, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      push("t6_post", BUS_NONE, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      go("t6_stale", BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd7, 64'h77,
         BUS_NONE, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      idle_cycle("t6_err", 1'b1, 1'b1);

      repeat (3) @(posedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
